// File: rtl/bram_port_arbiter.sv
// ---------------------------------------------------------------------------
// bram_port_arbiter
//
// Shares one 2^ADDR_W x DATA_W block RAM (separate write port, registered read
// port with one-cycle latency) between two masters using round-robin
// arbitration. At most one command is accepted per cycle; the selected command
// is registered onto the RAM ports. Read data is returned to the issuing
// requester exactly two cycles after acceptance via a small tag pipeline.
//
// Ports:
//   clk_i, reset_i              clock, asynchronous active-high reset
//   reqN_valid_i/_write_i       requester N command valid, 1 = write
//   reqN_addr_i/_wdata_i        requester N word address / write data
//   reqN_ready_o                combinational grant (accept = valid & ready)
//   rspN_valid_o                one-cycle pulse: rsp_data_o belongs to N
//   rsp_data_o                  shared read return (RAM read data passthrough)
//   mem_write_addr_o/_data_o    registered RAM write address / data
//   mem_write_enable_o          registered RAM write enable
//   mem_read_addr_o             registered RAM read address
//   mem_read_data_i             RAM read data, one cycle after read address
// ---------------------------------------------------------------------------
module bram_port_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              req0_valid_i,
  input  logic              req0_write_i,
  input  logic [ADDR_W-1:0] req0_addr_i,
  input  logic [DATA_W-1:0] req0_wdata_i,
  output logic              req0_ready_o,
  output logic              rsp0_valid_o,
  input  logic              req1_valid_i,
  input  logic              req1_write_i,
  input  logic [ADDR_W-1:0] req1_addr_i,
  input  logic [DATA_W-1:0] req1_wdata_i,
  output logic              req1_ready_o,
  output logic              rsp1_valid_o,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic [ADDR_W-1:0] mem_write_addr_o,
  output logic [DATA_W-1:0] mem_write_data_o,
  output logic              mem_write_enable_o,
  output logic [ADDR_W-1:0] mem_read_addr_o,
  input  logic [DATA_W-1:0] mem_read_data_i
);

  // Response tag travelling alongside an accepted read.
  typedef struct packed {
    logic valid;
    logic id;
  } tag_t;

  logic              grant0, grant1;
  logic              accept;
  logic              sel_id;
  logic              sel_write;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  logic              last_grant_q, last_grant_d;
  logic              mem_we_q,     mem_we_d;
  logic [ADDR_W-1:0] mem_waddr_q,  mem_waddr_d;
  logic [DATA_W-1:0] mem_wdata_q,  mem_wdata_d;
  logic [ADDR_W-1:0] mem_raddr_q,  mem_raddr_d;
  tag_t              stage1_q,     stage1_d;
  tag_t              stage2_q,     stage2_d;

  // Round-robin grant: a lone requester always wins; on a tie the requester
  // that was not granted most recently wins. last_grant_q resets to 1 so
  // requester 0 takes the first tie.
  always_comb begin
    grant0 = req0_valid_i & (~req1_valid_i | last_grant_q);
    grant1 = req1_valid_i & (~req0_valid_i | ~last_grant_q);
  end

  assign req0_ready_o = grant0;
  assign req1_ready_o = grant1;

  // Command mux; grant0 and grant1 are mutually exclusive.
  always_comb begin
    accept    = grant0 | grant1;
    sel_id    = grant1;
    sel_write = grant1 ? req1_write_i : req0_write_i;
    sel_addr  = grant1 ? req1_addr_i  : req0_addr_i;
    sel_wdata = grant1 ? req1_wdata_i : req0_wdata_i;
  end

  // Next-state logic.
  // NOTE: every signal gets a default at the top of the block so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    last_grant_d = last_grant_q;
    mem_we_d     = 1'b0;
    mem_waddr_d  = mem_waddr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_raddr_d  = mem_raddr_q;
    stage1_d     = '0;
    stage2_d     = stage1_q;

    if (accept) begin
      last_grant_d = sel_id;
      if (sel_write) begin
        mem_we_d    = 1'b1;
        mem_waddr_d = sel_addr;
        mem_wdata_d = sel_wdata;
      end else begin
        mem_raddr_d    = sel_addr;
        stage1_d.valid = 1'b1;
        stage1_d.id    = sel_id;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      last_grant_q <= 1'b1;
      mem_we_q     <= 1'b0;
      mem_waddr_q  <= '0;
      mem_wdata_q  <= '0;
      mem_raddr_q  <= '0;
      stage1_q     <= '0;
      stage2_q     <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      mem_we_q     <= mem_we_d;
      mem_waddr_q  <= mem_waddr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_raddr_q  <= mem_raddr_d;
      stage1_q     <= stage1_d;
      stage2_q     <= stage2_d;
    end
  end

  assign mem_write_enable_o = mem_we_q;
  assign mem_write_addr_o   = mem_waddr_q;
  assign mem_write_data_o   = mem_wdata_q;
  assign mem_read_addr_o    = mem_raddr_q;

  // Stage 2 lines up with the RAM's registered read data.
  assign rsp0_valid_o = stage2_q.valid & (stage2_q.id == 1'b0);
  assign rsp1_valid_o = stage2_q.valid & (stage2_q.id == 1'b1);
  assign rsp_data_o   = mem_read_data_i;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bram_port_arbiter
//
// Directed bench for bram_port_arbiter with a behavioural 256x16 RAM (write
// port plus registered read port) attached to the mem_* ports. Inputs change
// 1 ns after the rising edge; outputs are sampled 1-2 ns after the edge.
// ---------------------------------------------------------------------------
module tb_bram_port_arbiter;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;

  logic              clk;
  logic              reset_i;
  logic              req0_valid, req0_write, req0_ready, rsp0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic              req1_valid, req1_write, req1_ready, rsp1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic [DATA_W-1:0] rsp_data;
  logic [ADDR_W-1:0] mem_waddr, mem_raddr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              mem_we;

  int checks = 0;
  int errors = 0;

  bram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_i              (clk),
    .reset_i            (reset_i),
    .req0_valid_i       (req0_valid),
    .req0_write_i       (req0_write),
    .req0_addr_i        (req0_addr),
    .req0_wdata_i       (req0_wdata),
    .req0_ready_o       (req0_ready),
    .rsp0_valid_o       (rsp0_valid),
    .req1_valid_i       (req1_valid),
    .req1_write_i       (req1_write),
    .req1_addr_i        (req1_addr),
    .req1_wdata_i       (req1_wdata),
    .req1_ready_o       (req1_ready),
    .rsp1_valid_o       (rsp1_valid),
    .rsp_data_o         (rsp_data),
    .mem_write_addr_o   (mem_waddr),
    .mem_write_data_o   (mem_wdata),
    .mem_write_enable_o (mem_we),
    .mem_read_addr_o    (mem_raddr),
    .mem_read_data_i    (mem_rdata)
  );

  // Block RAM model: write at the edge, registered read of the sampled address.
  logic [DATA_W-1:0] ram [256];
  always @(posedge clk) begin
    if (mem_we) ram[mem_waddr] <= mem_wdata;
    mem_rdata <= ram[mem_raddr];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    check(tag, {15'd0, obs}, {15'd0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic v, input logic w, input logic [7:0] a, input logic [15:0] d);
    req0_valid = v; req0_write = w; req0_addr = a; req0_wdata = d;
  endtask

  task automatic set1(input logic v, input logic w, input logic [7:0] a, input logic [15:0] d);
    req1_valid = v; req1_write = w; req1_addr = a; req1_wdata = d;
  endtask

  task automatic idle();
    set0(1'b0, 1'b0, 8'h00, 16'h0000);
    set1(1'b0, 1'b0, 8'h00, 16'h0000);
  endtask

  task automatic check_reset_state(input string pfx);
    check_bit({pfx, "_we"},     mem_we,     1'b0);
    check    ({pfx, "_waddr"},  16'(mem_waddr), 16'h0000);
    check    ({pfx, "_wdata"},  mem_wdata,  16'h0000);
    check    ({pfx, "_raddr"},  16'(mem_raddr), 16'h0000);
    check_bit({pfx, "_rsp0"},   rsp0_valid, 1'b0);
    check_bit({pfx, "_rsp1"},   rsp1_valid, 1'b0);
    check_bit({pfx, "_ready0"}, req0_ready, 1'b0);
    check_bit({pfx, "_ready1"}, req1_ready, 1'b0);
  endtask

  initial begin
    logic exp0;

    // ---------------- reset, no requests ----------------
    reset_i = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1 reset_i = 1'b0;
    #1 check_reset_state("rst");

    // ---------------- write then read same address ----------------
    tick();
    set0(1'b1, 1'b1, 8'h12, 16'hBEEF);
    #1;
    check_bit("t2_ready0_wr", req0_ready, 1'b1);
    check_bit("t2_ready1_wr", req1_ready, 1'b0);
    tick();
    check_bit("t2_we_pulse", mem_we, 1'b1);
    check    ("t2_waddr",    16'(mem_waddr), 16'h0012);
    check    ("t2_wdata",    mem_wdata, 16'hBEEF);
    set0(1'b1, 1'b0, 8'h12, 16'h0000);
    #1 check_bit("t2_ready0_rd", req0_ready, 1'b1);
    tick();
    check_bit("t2_we_low", mem_we, 1'b0);
    check    ("t2_raddr",  16'(mem_raddr), 16'h0012);
    check_bit("t2_rsp0_early", rsp0_valid, 1'b0);
    idle();
    tick();
    check_bit("t2_rsp0",      rsp0_valid, 1'b1);
    check    ("t2_rsp_data",  rsp_data,   16'hBEEF);
    check_bit("t2_rsp1_low",  rsp1_valid, 1'b0);
    tick();
    check_bit("t2_rsp0_end",  rsp0_valid, 1'b0);

    // ---------------- req1 streams 256 writes ----------------
    for (int i = 0; i < 256; i++) begin
      set1(1'b1, 1'b1, 8'(i), 16'(i) ^ 16'hA5A5);
      #1 check_bit("t4_wr_ready1", req1_ready, 1'b1);
      tick();
    end
    // Readback stream: response for read k-2 is visible at the start of cycle k.
    for (int k = 0; k < 258; k++) begin
      if (k >= 2) begin
        check_bit("t4_rd_rsp1", rsp1_valid, 1'b1);
        check    ("t4_rd_data", rsp_data,   16'(k - 2) ^ 16'hA5A5);
      end else begin
        check_bit("t4_rd_rsp1_idle", rsp1_valid, 1'b0);
      end
      check_bit("t4_rd_rsp0", rsp0_valid, 1'b0);
      if (k < 256) set1(1'b1, 1'b0, 8'(k), 16'h0000);
      else         set1(1'b0, 1'b0, 8'h00, 16'h0000);
      #1;
      if (k < 256) check_bit("t4_rd_ready1", req1_ready, 1'b1);
      tick();
    end

    // ---------------- preload through the arbiter; ends with last_grant=1 ----------------
    set0(1'b1, 1'b1, 8'h01, 16'h1111);
    tick();
    set0(1'b0, 1'b0, 8'h00, 16'h0000);
    set1(1'b1, 1'b1, 8'h02, 16'h2222);
    tick();
    set1(1'b1, 1'b1, 8'h40, 16'h0000);
    tick();
    idle();
    tick();

    // ---------------- both requesters read continuously ----------------
    for (int k = 0; k < 8; k++) begin
      if (k >= 2) begin
        exp0 = ((k - 2) % 2 == 0);
        check_bit("t3_rsp0", rsp0_valid, exp0);
        check_bit("t3_rsp1", rsp1_valid, ~exp0);
        check    ("t3_data", rsp_data, exp0 ? 16'h1111 : 16'h2222);
      end else begin
        check_bit("t3_rsp0_idle", rsp0_valid, 1'b0);
        check_bit("t3_rsp1_idle", rsp1_valid, 1'b0);
      end
      if (k < 6) begin
        set0(1'b1, 1'b0, 8'h01, 16'h0000);
        set1(1'b1, 1'b0, 8'h02, 16'h0000);
      end else begin
        idle();
      end
      #1;
      if (k < 6) begin
        check_bit("t3_ready0", req0_ready, (k % 2 == 0));
        check_bit("t3_ready1", req1_ready, (k % 2 == 1));
      end
      tick();
    end

    // ---------------- tie: req0 write vs req1 read, same address ----------------
    set0(1'b1, 1'b1, 8'h40, 16'h1234);
    set1(1'b1, 1'b0, 8'h40, 16'h0000);
    #1;
    check_bit("t5_ready0", req0_ready, 1'b1);
    check_bit("t5_ready1", req1_ready, 1'b0);
    tick();
    check_bit("t5_we",    mem_we, 1'b1);
    check    ("t5_waddr", 16'(mem_waddr), 16'h0040);
    check    ("t5_wdata", mem_wdata, 16'h1234);
    set0(1'b0, 1'b0, 8'h00, 16'h0000);
    #1 check_bit("t5_ready1_next", req1_ready, 1'b1);
    tick();
    check_bit("t5_we_low", mem_we, 1'b0);
    check    ("t5_raddr",  16'(mem_raddr), 16'h0040);
    idle();
    tick();
    check_bit("t5_rsp1", rsp1_valid, 1'b1);
    check    ("t5_data", rsp_data,   16'h1234);
    check_bit("t5_rsp0", rsp0_valid, 1'b0);
    tick();

    // ---------------- reset with reads in flight ----------------
    set0(1'b1, 1'b0, 8'h01, 16'h0000);
    tick();
    set0(1'b0, 1'b0, 8'h00, 16'h0000);
    set1(1'b1, 1'b0, 8'h02, 16'h0000);
    tick();
    idle();
    reset_i = 1'b1;
    #1;
    check_bit("t6_rsp0_a", rsp0_valid, 1'b0);
    check_bit("t6_rsp1_a", rsp1_valid, 1'b0);
    tick();
    check_bit("t6_rsp0_b", rsp0_valid, 1'b0);
    check_bit("t6_rsp1_b", rsp1_valid, 1'b0);
    tick();
    reset_i = 1'b0;
    #1 check_reset_state("t6_post");
    tick();
    check_bit("t6_rsp0_c", rsp0_valid, 1'b0);
    check_bit("t6_rsp1_c", rsp1_valid, 1'b0);
    set0(1'b1, 1'b0, 8'h01, 16'h0000);
    set1(1'b1, 1'b0, 8'h02, 16'h0000);
    #1;
    check_bit("t6_tie_ready0", req0_ready, 1'b1);
    check_bit("t6_tie_ready1", req1_ready, 1'b0);
    tick();
    idle();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
